// File: rtl/mp_core_arbiter.sv
// mp_core_arbiter: round-robin front end that serialises core requests onto the mp_dut bus.
// Optional MP_ARB_TIMEOUT_EN: read-wait timeout that returns all-ones data with c_rerr.
module mp_core_arbiter #(
  parameter int NCORE = 4,
  parameter int AW    = 11,
  parameter int DW    = 8,
  parameter int OPW   = 2,
  parameter int TMO   = 64,
  localparam int CIW  = $clog2(NCORE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORE-1:0]     c_req,
  input  logic [NCORE-1:0]     c_we,
  input  logic [NCORE*OPW-1:0] c_opcode,
  input  logic [NCORE*AW-1:0]  c_addr,
  input  logic [NCORE*DW-1:0]  c_wdata,
  output logic [NCORE-1:0]     c_ack,
  output logic [NCORE-1:0]     c_rvalid,
  output logic [DW-1:0]        c_rdata,
  output logic                 c_rerr,
  output logic [CIW-1:0]       core_id,
  output logic [OPW-1:0]       opcode,
  output logic                 req,
  input  logic                 gnt,
  output logic                 we,
  output logic [AW-1:0]        addr,
  output logic [DW-1:0]        data_in,
  input  logic                 rvalid,
  input  logic [DW-1:0]        data_out,
  output logic [31:0]          burst_id,
  output logic                 err_stray
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } state_t;

  localparam logic [NCORE-1:0] ONE = NCORE'(1);

  state_t           state_q, state_d;
  logic [CIW-1:0]   rr_q, rr_d;
  logic [CIW-1:0]   cid_q, cid_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    din_q, din_d;
  logic             req_q, req_d;
  logic [NCORE-1:0] ack_q, ack_d;
  logic [NCORE-1:0] rv_q, rv_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [31:0]      burst_q, burst_d;
  logic             stray_q, stray_d;
  logic [CIW-1:0]   win, cand;

`ifdef MP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             rerr_q, rerr_d;
`endif

  // round-robin pick: first requester above rr, wrapping; nearest wins
  always_comb begin
    win  = rr_q;
    cand = '0;
    for (int i = NCORE; i >= 1; i--) begin
      cand = CIW'((int'(rr_q) + i) % NCORE);
      if (c_req[cand]) win = cand;
    end
  end

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cid_d   = cid_q;
    op_d    = op_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    req_d   = req_q;
    ack_d   = '0;
    rv_d    = '0;
    rdata_d = rdata_q;
    burst_d = burst_q;
    stray_d = stray_q;
`ifdef MP_ARB_TIMEOUT_EN
    tmo_d   = tmo_q;
    rerr_d  = 1'b0;
`endif
    if (rvalid && state_q != WAIT_R) stray_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (|c_req) begin
          state_d = REQ;
          rr_d    = win;
          cid_d   = win;
          we_d    = c_we[win];
          op_d    = c_opcode[int'(win)*OPW +: OPW];
          addr_d  = c_addr[int'(win)*AW +: AW];
          din_d   = c_wdata[int'(win)*DW +: DW];
          req_d   = 1'b1;
          ack_d   = ONE << win;
        end
      end
      REQ: begin
        if (gnt) begin
          req_d   = 1'b0;
          burst_d = burst_q + 32'd1;
          state_d = we_q ? IDLE : WAIT_R;
`ifdef MP_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      WAIT_R: begin
        if (rvalid) begin
          rv_d    = ONE << cid_q;
          rdata_d = data_out;
          state_d = IDLE;
        end
`ifdef MP_ARB_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TMO)) begin
            rv_d    = ONE << cid_q;
            rdata_d = '1;
            rerr_d  = 1'b1;
            state_d = IDLE;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; rr starts at the top so core 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= CIW'(NCORE - 1);
      cid_q   <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
      rv_q    <= '0;
      rdata_q <= '0;
      burst_q <= '0;
      stray_q <= 1'b0;
`ifdef MP_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      rerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cid_q   <= cid_d;
      op_q    <= op_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      burst_q <= burst_d;
      stray_q <= stray_d;
`ifdef MP_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      rerr_q  <= rerr_d;
`endif
    end
  end

  assign c_ack     = ack_q;
  assign c_rvalid  = rv_q;
  assign c_rdata   = rdata_q;
  assign core_id   = cid_q;
  assign opcode    = op_q;
  assign req       = req_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign data_in   = din_q;
  assign burst_id  = burst_q;
  assign err_stray = stray_q;
`ifdef MP_ARB_TIMEOUT_EN
  assign c_rerr    = rerr_q;
`else
  assign c_rerr    = 1'b0;
`endif

endmodule

// File: tb/tb_mp_core_arbiter.sv
// tb_mp_core_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbiter.
module tb_mp_core_arbiter;

  localparam int NCORE = 4;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int OPW   = 2;
  localparam int TMO   = 64;
  localparam int CIW   = $clog2(NCORE);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NCORE-1:0]     c_req = '0;
  logic [NCORE-1:0]     c_we = '0;
  logic [NCORE*OPW-1:0] c_opcode = '0;
  logic [NCORE*AW-1:0]  c_addr = '0;
  logic [NCORE*DW-1:0]  c_wdata = '0;
  logic [NCORE-1:0]     c_ack;
  logic [NCORE-1:0]     c_rvalid;
  logic [DW-1:0]        c_rdata;
  logic                 c_rerr;
  logic [CIW-1:0]       core_id;
  logic [OPW-1:0]       opcode;
  logic                 req;
  logic                 gnt = 1'b0;
  logic                 we;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        data_in;
  logic                 rvalid = 1'b0;
  logic [DW-1:0]        data_out = '0;
  logic [31:0]          burst_id;
  logic                 err_stray;

  mp_core_arbiter #(
    .NCORE(NCORE), .AW(AW), .DW(DW), .OPW(OPW), .TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_opcode(c_opcode),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .c_rerr(c_rerr), .core_id(core_id), .opcode(opcode),
    .req(req), .gnt(gnt), .we(we), .addr(addr),
    .data_in(data_in), .rvalid(rvalid), .data_out(data_out),
    .burst_id(burst_id), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: one transaction record plus expected bus outputs
  int          m_last;
  bit          m_act, m_wait, m_rd;
  int          m_core, m_wcnt;
  logic [31:0] m_burst;
  logic        m_stray;
  logic [NCORE-1:0] e_ack, e_rv;
  logic [DW-1:0]    e_rdata, e_din;
  logic             e_rerr, e_req, e_we;
  logic [CIW-1:0]   e_cid;
  logic [OPW-1:0]   e_op;
  logic [AW-1:0]    e_addr;

  bit [NCORE-1:0] pend;

  function automatic void chk(string n, logic [31:0] a,
                              logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endfunction

  task automatic model_reset();
    m_last = NCORE - 1;
    m_act = 0; m_wait = 0; m_rd = 0; m_core = 0; m_wcnt = 0;
    m_burst = '0; m_stray = 1'b0;
    e_ack = '0; e_rv = '0; e_rdata = '0; e_rerr = 1'b0;
    e_req = 1'b0; e_we = 1'b0; e_cid = '0; e_op = '0;
    e_addr = '0; e_din = '0;
  endtask

  // what the outputs must be after the next edge, given current inputs
  task automatic model_step();
    int w;
    bit found;
    e_ack = '0; e_rv = '0; e_rerr = 1'b0;
    if (rvalid && !(m_act && m_wait)) m_stray = 1'b1;
    if (!m_act) begin
      found = 0; w = 0;
      for (int k = 1; k <= NCORE; k++) begin
        int c;
        c = (m_last + k) % NCORE;
        if (!found && c_req[c]) begin found = 1; w = c; end
      end
      if (found) begin
        m_act = 1; m_wait = 0; m_core = w; m_rd = !c_we[w];
        m_last = w;
        e_cid = CIW'(w); e_we = c_we[w];
        e_op = c_opcode[w*OPW +: OPW];
        e_addr = c_addr[w*AW +: AW];
        e_din = c_wdata[w*DW +: DW];
        e_req = 1'b1; e_ack[w] = 1'b1;
      end
    end else if (!m_wait) begin
      if (gnt) begin
        m_burst = m_burst + 32'd1;
        e_req = 1'b0;
        if (m_rd) begin m_wait = 1; m_wcnt = 0; end
        else m_act = 0;
      end
    end else begin
      if (rvalid) begin
        e_rv[m_core] = 1'b1; e_rdata = data_out; m_act = 0;
      end
`ifdef MP_ARB_TIMEOUT_EN
      else begin
        m_wcnt++;
        if (m_wcnt == TMO) begin
          e_rv[m_core] = 1'b1; e_rdata = '1; e_rerr = 1'b1;
          m_act = 0;
        end
      end
`endif
    end
  endtask

  task automatic compare();
    chk("c_ack", 32'(c_ack), 32'(e_ack));
    chk("c_rvalid", 32'(c_rvalid), 32'(e_rv));
    chk("c_rdata", 32'(c_rdata), 32'(e_rdata));
    chk("c_rerr", 32'(c_rerr), 32'(e_rerr));
    chk("core_id", 32'(core_id), 32'(e_cid));
    chk("opcode", 32'(opcode), 32'(e_op));
    chk("req", 32'(req), 32'(e_req));
    chk("we", 32'(we), 32'(e_we));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("data_in", 32'(data_in), 32'(e_din));
    chk("burst_id", burst_id, m_burst);
    chk("err_stray", 32'(err_stray), 32'(m_stray));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic set_core(int i, bit w, logic [OPW-1:0] op,
                          logic [AW-1:0] a, logic [DW-1:0] d);
    c_req[i] = 1'b1;
    c_we[i] = w;
    c_opcode[i*OPW +: OPW] = op;
    c_addr[i*AW +: AW] = a;
    c_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    c_req = '0; gnt = 1'b0; rvalid = 1'b0; pend = '0;
    #1;
    chk("rst_c_ack", 32'(c_ack), 0);
    chk("rst_c_rvalid", 32'(c_rvalid), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_core_id", 32'(core_id), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_burst_id", burst_id, 0);
    chk("rst_err_stray", 32'(err_stray), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  int acks[$];
  int bids[$];
  int first_k;
  logic [NCORE-1:0] tv;
  logic [DW-1:0] trd;
  logic trerr;

  initial begin
    model_reset();
    pend = '0;
    #1;
    do_reset();

    // core 2 read 0x155, gnt next cycle, rvalid two cycles later
    set_core(2, 1'b0, 2'b01, 11'h155, 8'h00);
    tick();
    chk("t1_ack", 32'(c_ack), 32'h4);
    chk("t1_core_id", 32'(core_id), 2);
    chk("t1_addr", 32'(addr), 32'h155);
    chk("t1_we", 32'(we), 0);
    c_req = '0;
    gnt = 1'b1;
    tick();
    chk("t1_burst", burst_id, 1);
    gnt = 1'b0;
    tick();
    rvalid = 1'b1; data_out = 8'hA5;
    tick();
    chk("t1_rvalid", 32'(c_rvalid), 32'h4);
    chk("t1_rdata", 32'(c_rdata), 32'hA5);
    rvalid = 1'b0;
    tick();

    // all four cores read continuously
    do_reset();
    for (int i = 0; i < NCORE; i++)
      set_core(i, 1'b0, OPW'(i), AW'(16 * i), 8'h00);
    gnt = 1'b1;
    for (int t = 0; t < 40; t++) begin
      rvalid = m_act && m_wait;
      data_out = DW'($urandom);
      tick();
      for (int i = 0; i < NCORE; i++)
        if (c_ack[i]) begin acks.push_back(i); bids.push_back(int'(burst_id)); end
    end
    chk("t2_nacks_ge5", 32'(acks.size() >= 5), 1);
    if (acks.size() >= 5) begin
      chk("t2_order0", acks[0], 0);
      chk("t2_order1", acks[1], 1);
      chk("t2_order2", acks[2], 2);
      chk("t2_order3", acks[3], 3);
      chk("t2_order4", acks[4], 0);
      chk("t2_bid4", bids[4], 4);
    end
    gnt = 1'b0; rvalid = 1'b0;

    // core 1 write held off by gnt for five cycles
    do_reset();
    set_core(1, 1'b1, 2'b10, 11'h7FF, 8'h3C);
    tick();
    c_req = '0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t3_req", 32'(req), 1);
      chk("t3_addr", 32'(addr), 32'h7FF);
      chk("t3_din", 32'(data_in), 32'h3C);
    end
    gnt = 1'b1;
    tick();
    chk("t3_req_drop", 32'(req), 0);
    gnt = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("t3_no_rvalid", 32'(c_rvalid), 0);
    end

    // stray rvalid in idle, then a normal read
    rvalid = 1'b1; data_out = 8'h11;
    tick();
    chk("t4_stray", 32'(err_stray), 1);
    chk("t4_no_rvalid", 32'(c_rvalid), 0);
    rvalid = 1'b0;
    set_core(0, 1'b0, 2'b00, 11'h042, 8'h00);
    tick();
    c_req = '0; gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; data_out = 8'h5A;
    tick();
    chk("t4_rvalid", 32'(c_rvalid), 32'h1);
    chk("t4_rdata", 32'(c_rdata), 32'h5A);
    chk("t4_stray_kept", 32'(err_stray), 1);
    rvalid = 1'b0;

    // reset while core 3 waits for read data
    do_reset();
    set_core(3, 1'b0, 2'b11, 11'h300, 8'h00);
    tick();
    c_req = '0; gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("t5_no_rvalid", 32'(c_rvalid), 0);
    end
    set_core(0, 1'b0, 2'b00, 11'h001, 8'h00);
    set_core(3, 1'b0, 2'b00, 11'h003, 8'h00);
    tick();
    chk("t5_core0_wins", 32'(core_id), 0);
    chk("t5_ack0", 32'(c_ack), 32'h1);

    // read with no rvalid; another core queued behind it
    do_reset();
    set_core(0, 1'b0, 2'b01, 11'h0AA, 8'h00);
    tick();
    c_req = '0;
    set_core(1, 1'b0, 2'b01, 11'h0BB, 8'h00);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    first_k = 0; tv = '0; trd = '0; trerr = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (first_k == 0 && c_rvalid != '0) begin
        first_k = k; tv = c_rvalid; trd = c_rdata; trerr = c_rerr;
      end
    end
`ifdef MP_ARB_TIMEOUT_EN
    chk("t6_tmo_cycle", first_k, TMO);
    chk("t6_tmo_core", 32'(tv), 32'h1);
    chk("t6_tmo_rdata", 32'(trd), 32'hFF);
    chk("t6_tmo_rerr", 32'(trerr), 1);
`else
    chk("t6_no_rvalid", first_k, 0);
    chk("t6_still_wait_ack", 32'(c_ack), 0);
    chk("t6_still_wait_req", 32'(req), 0);
`endif

    // random traffic
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NCORE; i++)
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          set_core(i, 1'($urandom), OPW'($urandom),
                   AW'($urandom), DW'($urandom));
        end
      gnt = 1'($urandom);
      rvalid = (m_act && m_wait) ? ($urandom_range(2) == 0) : 1'b0;
      data_out = DW'($urandom);
      tick();
      for (int i = 0; i < NCORE; i++)
        if (e_ack[i]) begin pend[i] = 1'b0; c_req[i] = 1'b0; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
